// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, loadable instruction memory and instruction
// register. A loader write takes priority over PC/IR updates; bad fetches latch a halt opcode.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ext_imm,
  input  logic [31:0] jr_target,
  input  logic        prog_we,
  input  logic [9:0]  prog_addr,
  input  logic [31:0] prog_data,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] ir,
  output logic [5:0]  decode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm16,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] HaltInstr = 32'hFC00_0000;

  logic [31:0] imem_q [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;

  logic [31:0] next_pc;
  logic [31:0] fetch_word;
  logic        fetch_legal;
  logic        prog_in_range;

  assign pc4           = pc_q + 32'd4;
  assign fetch_word    = imem_q[pc_q[AW+1:2]];
  assign fetch_legal   = (pc_q[1:0] == 2'b00) && ({2'b00, pc_q[31:2]} < IMEM_DEPTH);
  assign prog_in_range = {22'd0, prog_addr} < IMEM_DEPTH;

  always_comb begin
    next_pc = pc4;
    unique case (PCSrc)
      2'b00: next_pc = pc4;
      2'b01: next_pc = pc4 + (ext_imm << 2);
      2'b10: next_pc = jr_target;
      2'b11: next_pc = {pc4[31:28], ir_q[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (!prog_we) begin
      if (PCWre && !fault_q) pc_d = next_pc;
      // IR always samples the word at the pre-update pc.
      if (IRWre) begin
        if (fetch_legal && !fault_q) begin
          ir_d  = fetch_word;
          cnt_d = cnt_q + 32'd1;
        end else begin
          ir_d    = HaltInstr;
          fault_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      cnt_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Memory contents survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (prog_we && prog_in_range) imem_q[prog_addr[AW-1:0]] <= prog_data;
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;
  assign decode      = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign sa          = ir_q[10:6];
  assign imm16       = ir_q[15:0];

endmodule
